vga_timing_gen: RTL and testbench

- Parametrised VGA raster timing generator. It replaces the fixed 800x525 counters and sync decode that are currently built into the controller.
- Produces the h/v counters, active-area pixel coordinates, frame/line strobes and sync/DE signals for any sync/porch/active geometry.
- Sync and DE are delayed by a configurable number of pixel ticks so they line up with a multi-stage pixel renderer downstream.
- Sits between the pixel-enable divider and the field/board renderer.

---
 rtl/vga_pkg.sv | 21 ++
 rtl/vga_delay_line.sv | 46 ++++
 rtl/vga_timing_gen.sv | 142 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing constants (default 640x480@60 geometry) and the pixel
// coordinate type used by the raster timing generator.
package vga_pkg;

  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BACK   = 48;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FRONT  = 16;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BACK   = 33;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FRONT  = 10;

  localparam int DEF_H_TOTAL = DEF_H_SYNC + DEF_H_BACK + DEF_H_ACTIVE + DEF_H_FRONT;
  localparam int DEF_V_TOTAL = DEF_V_SYNC + DEF_V_BACK + DEF_V_ACTIVE + DEF_V_FRONT;

  localparam int DEF_CNT_W = 10;

  typedef logic [DEF_CNT_W-1:0] pix_coord_t;

endpackage

// File: rtl/vga_delay_line.sv
// Enable-gated shift register of configurable width and depth; every stage
// resets to RST_VAL. Depth 0 is a plain wire.
module vga_delay_line #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_bypass
    logic unused_bypass;
    assign unused_bypass = ^{clk, rst_n, en};
    assign dout          = din;
  end else begin : g_shift
    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
      stage_d = stage_q;
      if (en) begin
        stage_d[0] = din;
        for (int i = 1; i < DEPTH; i++) begin
          stage_d[i] = stage_q[i-1];
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) begin
          stage_q[i] <= RST_VAL;
        end
      end else begin
        stage_q <= stage_d;
      end
    end

    assign dout = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: h/v counters, active-area decode,
// and sync/DE delayed to match the renderer. VGA_TIMING_FRAME_CNT_EN adds frame_cnt.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BACK     = DEF_H_BACK,
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FRONT    = DEF_H_FRONT,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BACK     = DEF_V_BACK,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FRONT    = DEF_V_FRONT,
  parameter bit HS_POL     = 1'b0,
  parameter bit VS_POL     = 1'b0,
  parameter int PIPE_DELAY = 1,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vga_clk,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic             in_active,
  output logic             line_start,
  output logic             frame_start,
  output logic             hor_sync,
  output logic             ver_sync,
  output logic             de
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0]      frame_cnt
`endif
);

  localparam int H_TOTAL   = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL   = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int MAX_TOTAL = (H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_SYNC_W = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_W = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] H_ACT_LO = CNT_W'(H_SYNC + H_BACK);
  localparam logic [CNT_W-1:0] H_ACT_HI = CNT_W'(H_SYNC + H_BACK + H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] V_ACT_LO = CNT_W'(V_SYNC + V_BACK);
  localparam logic [CNT_W-1:0] V_ACT_HI = CNT_W'(V_SYNC + V_BACK + V_ACTIVE - 1);

  if ((64'd1 << CNT_W) < 64'(MAX_TOTAL)) begin : g_err_cnt_w
    $error("vga_timing_gen: CNT_W too narrow for H_TOTAL/V_TOTAL");
  end
  if (H_SYNC == 0 || H_BACK == 0 || H_ACTIVE == 0 || H_FRONT == 0 ||
      V_SYNC == 0 || V_BACK == 0 || V_ACTIVE == 0 || V_FRONT == 0) begin : g_err_region
    $error("vga_timing_gen: every sync/porch/active region must be non-zero");
  end
  if (PIPE_DELAY < 0 || PIPE_DELAY > 8) begin : g_err_delay
    $error("vga_timing_gen: PIPE_DELAY must be in 0..8");
  end

  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
  logic             h_wrap, v_wrap;
  logic             h_act, v_act;
  logic             hs_raw, vs_raw;

  assign h_wrap = (h_cnt_q == H_LAST);
  assign v_wrap = (v_cnt_q == V_LAST);

  // v_cnt advances on the same tick h_cnt wraps, so a new line starts with its final v value
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (vga_clk) begin
      if (h_wrap) begin
        h_cnt_d = '0;
        v_cnt_d = v_wrap ? '0 : v_cnt_q + CNT_W'(1);
      end else begin
        h_cnt_d = h_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign h_act = (h_cnt_q >= H_ACT_LO) && (h_cnt_q <= H_ACT_HI);
  assign v_act = (v_cnt_q >= V_ACT_LO) && (v_cnt_q <= V_ACT_HI);

  assign h_cnt       = h_cnt_q;
  assign v_cnt       = v_cnt_q;
  assign pix_x       = h_act ? (h_cnt_q - H_ACT_LO) : '0;
  assign pix_y       = v_act ? (v_cnt_q - V_ACT_LO) : '0;
  assign in_active   = h_act && v_act;
  assign line_start  = (h_cnt_q == '0);
  assign frame_start = (h_cnt_q == '0) && (v_cnt_q == '0);

  assign hs_raw = (h_cnt_q < H_SYNC_W) ? HS_POL : ~HS_POL;
  assign vs_raw = (v_cnt_q < V_SYNC_W) ? VS_POL : ~VS_POL;

  vga_delay_line #(
    .WIDTH   (3),
    .DEPTH   (PIPE_DELAY),
    .RST_VAL ({~HS_POL, ~VS_POL, 1'b0})
  ) u_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (vga_clk),
    .din   ({hs_raw, vs_raw, in_active}),
    .dout  ({hor_sync, ver_sync, de})
  );

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (vga_clk && h_wrap && v_wrap) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: three geometries driven in lockstep,
// checked every cycle against a tick-count arithmetic reference model.
module tb_vga_timing_gen;

  typedef struct { int hs, hb, ha, hf, vs, vb, va, vf, hpol, vpol, pd; } geo_t;
  typedef struct { logic [31:0] h, v, px, py, act, ls, fs, hsy, vsy, de, fc; } obs_t;

  logic clk = 1'b0;
  logic rst_n;
  logic vga_clk;
  always #5 clk = ~clk;

  int   t;
  int   n_tests;
  int   n_fail;
  geo_t g_def, g_sml, g_z;

  logic [9:0] d_h, d_v, d_px, d_py;
  logic       d_act, d_ls, d_fs, d_hs, d_vs, d_de;
  logic [4:0] s_h, s_v, s_px, s_py;
  logic       s_act, s_ls, s_fs, s_hs, s_vs, s_de;
  logic [3:0] z_h, z_v, z_px, z_py;
  logic       z_act, z_ls, z_fs, z_hs, z_vs, z_de;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] d_fc, s_fc, z_fc;
`endif

  vga_timing_gen u_def (
    .clk(clk), .rst_n(rst_n), .vga_clk(vga_clk),
    .h_cnt(d_h), .v_cnt(d_v), .pix_x(d_px), .pix_y(d_py),
    .in_active(d_act), .line_start(d_ls), .frame_start(d_fs),
    .hor_sync(d_hs), .ver_sync(d_vs), .de(d_de)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(d_fc)
`endif
  );

  vga_timing_gen #(
    .H_SYNC(3), .H_BACK(2), .H_ACTIVE(5), .H_FRONT(2),
    .V_SYNC(2), .V_BACK(1), .V_ACTIVE(4), .V_FRONT(2),
    .HS_POL(1'b1), .VS_POL(1'b1), .PIPE_DELAY(3), .CNT_W(5)
  ) u_sml (
    .clk(clk), .rst_n(rst_n), .vga_clk(vga_clk),
    .h_cnt(s_h), .v_cnt(s_v), .pix_x(s_px), .pix_y(s_py),
    .in_active(s_act), .line_start(s_ls), .frame_start(s_fs),
    .hor_sync(s_hs), .ver_sync(s_vs), .de(s_de)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(s_fc)
`endif
  );

  vga_timing_gen #(
    .H_SYNC(2), .H_BACK(3), .H_ACTIVE(4), .H_FRONT(1),
    .V_SYNC(1), .V_BACK(2), .V_ACTIVE(3), .V_FRONT(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .PIPE_DELAY(0), .CNT_W(4)
  ) u_z (
    .clk(clk), .rst_n(rst_n), .vga_clk(vga_clk),
    .h_cnt(z_h), .v_cnt(z_v), .pix_x(z_px), .pix_y(z_py),
    .in_active(z_act), .line_start(z_ls), .frame_start(z_fs),
    .hor_sync(z_hs), .ver_sync(z_vs), .de(z_de)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(z_fc)
`endif
  );

  function automatic bit in_rng(input int x, input int lo, input int n);
    return (x >= lo) && (x < lo + n);
  endfunction

  // Reference: everything follows from the number of pixel ticks since reset.
  function automatic obs_t model(input geo_t g, input int tk);
    obs_t e;
    int ht, vt, h, v, hd, vd, hlo, vlo;
    ht  = g.hs + g.hb + g.ha + g.hf;
    vt  = g.vs + g.vb + g.va + g.vf;
    hlo = g.hs + g.hb;
    vlo = g.vs + g.vb;
    h   = tk % ht;
    v   = (tk / ht) % vt;
    e.h   = 32'(h);
    e.v   = 32'(v);
    e.px  = in_rng(h, hlo, g.ha) ? 32'(h - hlo) : 32'd0;
    e.py  = in_rng(v, vlo, g.va) ? 32'(v - vlo) : 32'd0;
    e.act = 32'(in_rng(h, hlo, g.ha) && in_rng(v, vlo, g.va));
    e.ls  = 32'(h == 0);
    e.fs  = 32'(h == 0 && v == 0);
    if (tk >= g.pd) begin
      hd = (tk - g.pd) % ht;
      vd = ((tk - g.pd) / ht) % vt;
      e.hsy = 32'((hd < g.hs) ? g.hpol : 1 - g.hpol);
      e.vsy = 32'((vd < g.vs) ? g.vpol : 1 - g.vpol);
      e.de  = 32'(in_rng(hd, hlo, g.ha) && in_rng(vd, vlo, g.va));
    end else begin
      e.hsy = 32'(1 - g.hpol);
      e.vsy = 32'(1 - g.vpol);
      e.de  = 32'd0;
    end
    e.fc = 32'((tk / (ht * vt)) % 65536);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_dut(input string nm, input geo_t g, input obs_t o);
    obs_t e;
    e = model(g, t);
    chk({nm, ".h_cnt"},       o.h,   e.h);
    chk({nm, ".v_cnt"},       o.v,   e.v);
    chk({nm, ".pix_x"},       o.px,  e.px);
    chk({nm, ".pix_y"},       o.py,  e.py);
    chk({nm, ".in_active"},   o.act, e.act);
    chk({nm, ".line_start"},  o.ls,  e.ls);
    chk({nm, ".frame_start"}, o.fs,  e.fs);
    chk({nm, ".hor_sync"},    o.hsy, e.hsy);
    chk({nm, ".ver_sync"},    o.vsy, e.vsy);
    chk({nm, ".de"},          o.de,  e.de);
`ifdef VGA_TIMING_FRAME_CNT_EN
    chk({nm, ".frame_cnt"},   o.fc,  e.fc);
`endif
  endtask

  task automatic check_all();
    obs_t o;
    o.fc = '0;
    o.h = 32'(d_h); o.v = 32'(d_v); o.px = 32'(d_px); o.py = 32'(d_py);
    o.act = 32'(d_act); o.ls = 32'(d_ls); o.fs = 32'(d_fs);
    o.hsy = 32'(d_hs); o.vsy = 32'(d_vs); o.de = 32'(d_de);
`ifdef VGA_TIMING_FRAME_CNT_EN
    o.fc = 32'(d_fc);
`endif
    check_dut("def", g_def, o);
    o.h = 32'(s_h); o.v = 32'(s_v); o.px = 32'(s_px); o.py = 32'(s_py);
    o.act = 32'(s_act); o.ls = 32'(s_ls); o.fs = 32'(s_fs);
    o.hsy = 32'(s_hs); o.vsy = 32'(s_vs); o.de = 32'(s_de);
`ifdef VGA_TIMING_FRAME_CNT_EN
    o.fc = 32'(s_fc);
`endif
    check_dut("sml", g_sml, o);
    o.h = 32'(z_h); o.v = 32'(z_v); o.px = 32'(z_px); o.py = 32'(z_py);
    o.act = 32'(z_act); o.ls = 32'(z_ls); o.fs = 32'(z_fs);
    o.hsy = 32'(z_hs); o.vsy = 32'(z_vs); o.de = 32'(z_de);
`ifdef VGA_TIMING_FRAME_CNT_EN
    o.fc = 32'(z_fc);
`endif
    check_dut("z", g_z, o);
  endtask

  // Drive one clk cycle with the given enable, then check at the falling edge.
  task automatic step(input logic en);
    vga_clk = en;
    @(posedge clk);
    if (en && rst_n) t++;
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset(input int hold);
    rst_n = 1'b0;
    t     = 0;
    #1;
    check_all();
    chk("rst.def_h_cnt",    32'(d_h),  32'd0);
    chk("rst.def_v_cnt",    32'(d_v),  32'd0);
    chk("rst.def_hor_sync", 32'(d_hs), 32'd1);
    chk("rst.def_ver_sync", 32'(d_vs), 32'd1);
    chk("rst.def_de",       32'(d_de), 32'd0);
    chk("rst.sml_hor_sync", 32'(s_hs), 32'd0);
    chk("rst.sml_ver_sync", 32'(s_vs), 32'd0);
    chk("rst.sml_de",       32'(s_de), 32'd0);
    for (int i = 0; i < hold; i++) step(1'($urandom_range(0, 1)));
    rst_n = 1'b1;
  endtask

  initial begin
    int fs1, fs2, ls1, ls2;
    logic ls_prev;
    g_def   = '{96, 48, 640, 16, 2, 33, 480, 10, 0, 0, 1};
    g_sml   = '{3, 2, 5, 2, 2, 1, 4, 2, 1, 1, 3};
    g_z     = '{2, 3, 4, 1, 1, 2, 3, 1, 0, 0, 0};
    n_tests = 0;
    n_fail  = 0;
    t       = 0;
    rst_n   = 1'b1;
    vga_clk = 1'b0;
    #2;
    do_reset(2);

    // Continuous ticks through the first default active lines.
    fs1 = -1;
    fs2 = -1;
    for (int i = 0; i < 29000; i++) begin
      step(1'b1);
      if (t == 24) begin
        chk("sml.v_adv_h", 32'(s_h), 32'd0);
        chk("sml.v_adv_v", 32'(s_v), 32'd2);
      end
      if (t == 43) chk("sml.de_before_rise", 32'(s_de), 32'd0);
      if (t == 44) chk("sml.de_rise_h8",     32'(s_de), 32'd1);
      if (t == 107) begin
        chk("sml.last_h", 32'(s_h), 32'd11);
        chk("sml.last_v", 32'(s_v), 32'd8);
      end
      if (t == 108) begin
        chk("sml.wrap_h",  32'(s_h),  32'd0);
        chk("sml.wrap_v",  32'(s_v),  32'd0);
        chk("sml.wrap_fs", 32'(s_fs), 32'd1);
      end
      if (t == 35 * 800 + 144) begin
        chk("def.pix_x_at_144", 32'(d_px), 32'd0);
        chk("def.de_at_144",    32'(d_de), 32'd0);
      end
      if (t == 35 * 800 + 145) begin
        chk("def.pix_x_at_145", 32'(d_px), 32'd1);
        chk("def.de_at_145",    32'(d_de), 32'd1);
      end
      if (s_fs && t > 0) begin
        if (fs1 < 0) fs1 = t;
        else if (fs2 < 0) fs2 = t;
      end
    end
    chk("sml.ticks_per_frame", 32'(fs2 - fs1), 32'd108);

    // Pixel enable on every other clk: a default line spans 1600 clk cycles.
    ls1     = -1;
    ls2     = -1;
    ls_prev = d_ls;
    for (int i = 0; i < 3400; i++) begin
      step(1'(i % 2 == 0));
      if (d_ls && !ls_prev) begin
        if (ls1 < 0) ls1 = i;
        else if (ls2 < 0) ls2 = i;
      end
      ls_prev = d_ls;
    end
    chk("def.line_len_clk", 32'(ls2 - ls1), 32'd1600);

    // Mid-frame reset, then restart and run three small frames.
    do_reset(3);
    chk("rel.def_frame_start", 32'(d_fs), 32'd1);
    chk("rel.sml_frame_start", 32'(s_fs), 32'd1);
    chk("rel.z_frame_start",   32'(z_fs), 32'd1);
    for (int i = 0; i < 3 * 108; i++) step(1'b1);
`ifdef VGA_TIMING_FRAME_CNT_EN
    chk("sml.frame_cnt_3", 32'(s_fc), 32'd3);
`endif
    chk("sml.after_3_frames_fs", 32'(s_fs), 32'd1);

    // Random enable pattern with occasional random resets.
    for (int i = 0; i < 20000; i++) begin
      if ($urandom_range(0, 3999) == 0) do_reset(int'($urandom_range(1, 3)));
      else step(1'($urandom_range(0, 3) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
